wb_instr_responder: RTL and testbench

Parametrised Wishbone classic slave that serves the core's instruction/data fetches from a testbench-loaded word FIFO. It is the synthesisable successor to the fixed 128-bit instruction-injection scheme. It adds configurable bus and word widths, FIFO depth, lane placement by address, programmable wait states, error injection, underrun detection and write capture for the monitor. It sits between the UVM driver/monitor and the DUT core's Wishbone master port.

---
 rtl/wb_resp_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/wb_instr_responder.sv | 187 ++++++++++++++++++
 tb/tb_wb_instr_responder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_resp_pkg.sv
// Shared types and helpers for the Wishbone instruction responder:
// FSM state encoding, wait-state counter type and lane selection.
package wb_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_t;

  typedef logic [3:0] wait_cnt_t;

  localparam logic [31:0] FILL_WORD_DEFAULT = 32'hF0081003;

  // Word lane addressed within the bus beat: byte address stripped of the
  // in-word offset, reduced to the number of lanes on the bus.
  function automatic int unsigned lane_index(input logic [31:0] adr,
                                             input int unsigned byte_shift,
                                             input int unsigned lanes);
    return (adr >> byte_shift) % lanes;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full and empty are told apart by
// an extra wrap bit on each pointer.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign o_dout  = mem[rd_ptr[AW-1:0]];
  assign o_level = wr_ptr - rd_ptr;
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/wb_instr_responder.sv
// Wishbone classic slave answering fetches from a preloaded word FIFO, with
// programmable wait states, error injection, underrun flag and write capture.
module wb_instr_responder
  import wb_resp_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                WORD_W    = 32,
  parameter int                DEPTH     = 8,
  parameter logic [WORD_W-1:0] FILL_WORD = FILL_WORD_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_ld_valid,
  input  logic [WORD_W-1:0]      i_ld_word,
  output logic                   o_ld_ready,
  input  logic [3:0]             i_wait_cycles,
  input  logic                   i_err_inject,
  input  logic [31:0]            i_wb_adr,
  input  logic [DATA_W/8-1:0]    i_wb_sel,
  input  logic                   i_wb_we,
  input  logic [DATA_W-1:0]      i_wb_dat,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  output logic [DATA_W-1:0]      o_wb_dat,
  output logic                   o_wb_ack,
  output logic                   o_wb_err,
  output logic                   o_wr_valid,
  output logic [31:0]            o_wr_adr,
  output logic [DATA_W-1:0]      o_wr_dat,
  output logic [DATA_W/8-1:0]    o_wr_sel,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_underrun
);

  localparam int unsigned LANES      = DATA_W / WORD_W;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_W / 8);

  resp_state_t         state;
  wait_cnt_t           wait_cnt;
  logic [31:0]         req_adr;
  logic                req_we;
  logic [DATA_W/8-1:0] req_sel;
  logic [DATA_W-1:0]   req_dat;
  logic                req_err;
  logic                err_pending;

  logic                req_active;
  logic                go_resp;
  logic                resp_we;
  logic                resp_err;
  logic [31:0]         resp_adr;
  logic [DATA_W/8-1:0] resp_sel;
  logic [DATA_W-1:0]   resp_dat;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [WORD_W-1:0]   fifo_dout;
  logic [DATA_W-1:0]   rd_data;
  int unsigned         rd_lane;

  assign req_active = i_wb_cyc && i_wb_stb;
  assign fifo_push  = i_ld_valid && !fifo_full;
  assign o_ld_ready = !fifo_full;
  // The word is consumed on the same edge that registers it onto the bus.
  assign fifo_pop   = go_resp && !resp_we && !resp_err;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_din   (i_ld_word),
    .i_pop   (fifo_pop),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  // Request attributes seen by the response: live bus inputs on a zero-wait
  // acceptance, latched copies otherwise. go_resp marks the edge entering RESP.
  always_comb begin
    go_resp  = 1'b0;
    resp_we  = req_we;
    resp_adr = req_adr;
    resp_sel = req_sel;
    resp_dat = req_dat;
    resp_err = req_err;
    case (state)
      ST_IDLE: begin
        if (req_active) begin
          resp_we  = i_wb_we;
          resp_adr = i_wb_adr;
          resp_sel = i_wb_sel;
          resp_dat = i_wb_dat;
          resp_err = err_pending | i_err_inject;
          go_resp  = (i_wait_cycles == '0);
        end
      end
      ST_WAIT: go_resp = req_active && (wait_cnt == wait_cnt_t'(1));
      default: ;
    endcase
  end

  always_comb begin
    rd_lane = lane_index(resp_adr, WORD_SHIFT, LANES);
    rd_data = {LANES{FILL_WORD}};
    for (int unsigned l = 0; l < LANES; l++) begin
      if (!fifo_empty && l == rd_lane) rd_data[l*WORD_W +: WORD_W] = fifo_dout;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      req_adr     <= '0;
      req_we      <= 1'b0;
      req_sel     <= '0;
      req_dat     <= '0;
      req_err     <= 1'b0;
      err_pending <= 1'b0;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      o_wb_dat    <= '0;
      o_wr_valid  <= 1'b0;
      o_wr_adr    <= '0;
      o_wr_dat    <= '0;
      o_wr_sel    <= '0;
      o_underrun  <= 1'b0;
    end else begin
      o_wb_ack   <= 1'b0;
      o_wb_err   <= 1'b0;
      o_wb_dat   <= '0;
      o_wr_valid <= 1'b0;
      if (i_err_inject) err_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (req_active) begin
            req_adr     <= resp_adr;
            req_we      <= resp_we;
            req_sel     <= resp_sel;
            req_dat     <= resp_dat;
            req_err     <= resp_err;
            err_pending <= 1'b0;
            wait_cnt    <= i_wait_cycles;
            state       <= (i_wait_cycles == '0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // An aborted request hands its error back so the next one still gets it.
          if (!req_active) begin
            state       <= ST_IDLE;
            err_pending <= err_pending | req_err | i_err_inject;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
            if (wait_cnt == wait_cnt_t'(1)) state <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (go_resp) begin
        if (resp_err) begin
          o_wb_err <= 1'b1;
        end else begin
          o_wb_ack <= 1'b1;
          if (resp_we) begin
            o_wr_valid <= 1'b1;
            o_wr_adr   <= resp_adr;
            o_wr_dat   <= resp_dat;
            o_wr_sel   <= resp_sel;
          end else begin
            o_wb_dat <= rd_data;
            if (fifo_empty) o_underrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_instr_responder.sv
// Directed bench for wb_instr_responder: a time-stamped transaction model with
// a word queue is compared against the DUT every cycle, plus literal checks.
module tb_wb_instr_responder;

  localparam int DATA_W = 128;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 8;
  localparam int LANES  = DATA_W / WORD_W;
  localparam int SEL_W  = DATA_W / 8;
  localparam logic [31:0] FILL = 32'hF0081003;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   i_ld_valid = 1'b0;
  logic [WORD_W-1:0]      i_ld_word = '0;
  logic                   o_ld_ready;
  logic [3:0]             i_wait_cycles = '0;
  logic                   i_err_inject = 1'b0;
  logic [31:0]            i_wb_adr = '0;
  logic [SEL_W-1:0]       i_wb_sel = '0;
  logic                   i_wb_we = 1'b0;
  logic [DATA_W-1:0]      i_wb_dat = '0;
  logic                   i_wb_cyc = 1'b0;
  logic                   i_wb_stb = 1'b0;
  logic [DATA_W-1:0]      o_wb_dat;
  logic                   o_wb_ack;
  logic                   o_wb_err;
  logic                   o_wr_valid;
  logic [31:0]            o_wr_adr;
  logic [DATA_W-1:0]      o_wr_dat;
  logic [SEL_W-1:0]       o_wr_sel;
  logic [$clog2(DEPTH):0] o_level;
  logic                   o_underrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_instr_responder #(
    .DATA_W (DATA_W),
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ld_valid    (i_ld_valid),
    .i_ld_word     (i_ld_word),
    .o_ld_ready    (o_ld_ready),
    .i_wait_cycles (i_wait_cycles),
    .i_err_inject  (i_err_inject),
    .i_wb_adr      (i_wb_adr),
    .i_wb_sel      (i_wb_sel),
    .i_wb_we       (i_wb_we),
    .i_wb_dat      (i_wb_dat),
    .i_wb_cyc      (i_wb_cyc),
    .i_wb_stb      (i_wb_stb),
    .o_wb_dat      (o_wb_dat),
    .o_wb_ack      (o_wb_ack),
    .o_wb_err      (o_wb_err),
    .o_wr_valid    (o_wr_valid),
    .o_wr_adr      (o_wr_adr),
    .o_wr_dat      (o_wr_dat),
    .o_wr_sel      (o_wr_sel),
    .o_level       (o_level),
    .o_underrun    (o_underrun)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: a request accepted on edge k terminates on edge k+W,
  // and the earliest next acceptance is two edges after a termination.
  logic [WORD_W-1:0] mq[$];
  int                edge_no = 0;
  int                m_due = 0;
  int                m_next_ok = 0;
  int                size0;
  int                lane;
  bit                m_busy = 0, m_pend = 0, m_err = 0, m_we = 0, m_under = 0;
  bit                req, fire, do_pop;
  logic [31:0]       m_adr = '0;
  logic [SEL_W-1:0]  m_sel = '0;
  logic [DATA_W-1:0] m_wdat = '0;
  bit                e_ack = 0, e_err = 0, e_wr = 0, e_dat_valid = 1;
  logic [DATA_W-1:0] e_dat = '0;
  int                e_level = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      edge_no = 0; m_next_ok = 0; m_busy = 0; m_pend = 0; m_under = 0;
      e_ack = 0; e_err = 0; e_wr = 0; e_dat = '0; e_dat_valid = 1; e_level = 0;
    end else begin
      edge_no++;
      req = i_wb_cyc && i_wb_stb;
      fire = 0; do_pop = 0;
      size0 = mq.size();
      e_ack = 0; e_err = 0; e_wr = 0; e_dat = '0; e_dat_valid = 1;
      if (m_busy) begin
        if (!req) begin
          m_busy = 0;
          m_pend = m_pend | m_err | i_err_inject;
        end else begin
          if (i_err_inject) m_pend = 1;
          if (edge_no == m_due) fire = 1;
        end
      end else if (req && edge_no >= m_next_ok) begin
        m_adr = i_wb_adr; m_we = i_wb_we; m_sel = i_wb_sel; m_wdat = i_wb_dat;
        m_err = m_pend | i_err_inject;
        m_pend = 0;
        m_due = edge_no + int'(i_wait_cycles);
        m_busy = 1;
        if (m_due == edge_no) fire = 1;
      end else if (i_err_inject) begin
        m_pend = 1;
      end
      if (fire) begin
        m_busy = 0;
        m_next_ok = edge_no + 2;
        if (m_err) begin
          e_err = 1;
        end else begin
          e_ack = 1;
          if (m_we) begin
            e_wr = 1;
            e_dat_valid = 0;
          end else begin
            lane = int'((m_adr / (WORD_W / 8)) % LANES);
            for (int l = 0; l < LANES; l++)
              e_dat[l*WORD_W +: WORD_W] = (l == lane && size0 > 0) ? mq[0] : FILL;
            if (size0 == 0) m_under = 1;
            else do_pop = 1;
          end
        end
      end
      if (i_ld_valid && size0 < DEPTH) mq.push_back(i_ld_word);
      if (do_pop) void'(mq.pop_front());
      e_level = mq.size();
    end
  end

  always @(negedge clk) begin
    check("ack", DATA_W'(o_wb_ack), DATA_W'(e_ack));
    check("err", DATA_W'(o_wb_err), DATA_W'(e_err));
    check("level", DATA_W'(o_level), DATA_W'(e_level));
    check("ld_ready", DATA_W'(o_ld_ready), DATA_W'(e_level < DEPTH));
    check("underrun", DATA_W'(o_underrun), DATA_W'(m_under));
    check("wr_valid", DATA_W'(o_wr_valid), DATA_W'(e_wr));
    if (e_dat_valid) check("wb_dat", o_wb_dat, e_dat);
    if (e_wr) begin
      check("wr_adr", DATA_W'(o_wr_adr), DATA_W'(m_adr));
      check("wr_dat", o_wr_dat, m_wdat);
      check("wr_sel", DATA_W'(o_wr_sel), DATA_W'(m_sel));
    end
  end

  int                cap_lat;
  logic              cap_ack, cap_err, cap_wr, cap_under;
  logic [DATA_W-1:0] cap_dat, cap_wdat;
  logic [31:0]       cap_wadr;
  logic [SEL_W-1:0]  cap_wsel;
  logic [$clog2(DEPTH):0] cap_level;
  bit                saw;

  task automatic load(input logic [WORD_W-1:0] w);
    i_ld_valid = 1'b1;
    i_ld_word  = w;
    @(negedge clk);
    i_ld_valid = 1'b0;
  endtask

  // Issue one request and capture the termination cycle's outputs; cap_lat is
  // the number of falling edges from request to the visible ack/err.
  task automatic do_req(input logic [31:0] adr, input logic we,
                        input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] dat,
                        input logic [3:0] w);
    int n;
    i_wb_adr = adr; i_wb_we = we; i_wb_sel = sel; i_wb_dat = dat;
    i_wait_cycles = w;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    cap_lat = 0; n = 0;
    while (cap_lat == 0 && n < 40) begin
      @(negedge clk);
      i_ld_valid = 1'b0;
      n++;
      if (o_wb_ack || o_wb_err) cap_lat = n;
    end
    if (cap_lat == 0) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: got no termination, required ack or err within 40 cycles");
    end
    cap_ack = o_wb_ack; cap_err = o_wb_err; cap_dat = o_wb_dat; cap_level = o_level;
    cap_wr = o_wr_valid; cap_wadr = o_wr_adr; cap_wdat = o_wr_dat; cap_wsel = o_wr_sel;
    cap_under = o_underrun;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", DATA_W'(o_wb_ack), '0);
    check("rst_level", DATA_W'(o_level), '0);
    check("rst_ready", DATA_W'(o_ld_ready), DATA_W'(1));
    check("rst_dat", o_wb_dat, '0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait read into lane 2
    load(32'hE3A00001);
    check("load_level", DATA_W'(o_level), DATA_W'(1));
    do_req(32'h8, 1'b0, '1, '0, 4'd0);
    check("lat_w0", DATA_W'(cap_lat), DATA_W'(1));
    check("rd_lane2", cap_dat, 128'hF0081003_E3A00001_F0081003_F0081003);
    check("pop_level", DATA_W'(cap_level), '0);

    // Three wait states
    load(32'h11111111);
    do_req(32'h0, 1'b0, '1, '0, 4'd3);
    check("lat_w3", DATA_W'(cap_lat), DATA_W'(4));
    check("rd_lane0", cap_dat, 128'hF0081003_F0081003_F0081003_11111111);

    // Strobe dropped in the second wait cycle
    load(32'h22222222);
    i_wb_adr = '0; i_wb_we = 1'b0; i_wait_cycles = 4'd3;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_wb_ack || o_wb_err) saw = 1;
    end
    check("abort_no_ack", DATA_W'(saw), '0);
    check("abort_level", DATA_W'(o_level), DATA_W'(1));
    do_req(32'h4, 1'b0, '1, '0, 4'd1);
    check("lat_w1", DATA_W'(cap_lat), DATA_W'(2));
    check("rd_lane1", cap_dat, 128'hF0081003_F0081003_22222222_F0081003);

    // Empty FIFO read
    do_req(32'hC, 1'b0, '1, '0, 4'd2);
    check("empty_ack", DATA_W'(cap_ack), DATA_W'(1));
    check("empty_dat", cap_dat, {LANES{FILL}});
    check("empty_underrun", DATA_W'(cap_under), DATA_W'(1));

    // Error injection, then a normal read
    i_err_inject = 1'b1;
    @(negedge clk);
    i_err_inject = 1'b0;
    load(32'h33333333);
    do_req(32'h0, 1'b0, '1, '0, 4'd0);
    check("inj_err", DATA_W'(cap_err), DATA_W'(1));
    check("inj_no_ack", DATA_W'(cap_ack), '0);
    check("inj_level", DATA_W'(cap_level), DATA_W'(1));
    check("inj_dat", cap_dat, '0);
    do_req(32'h0, 1'b0, '1, '0, 4'd0);
    check("post_err_ack", DATA_W'(cap_ack), DATA_W'(1));
    check("post_err_dat", cap_dat, 128'hF0081003_F0081003_F0081003_33333333);
    check("underrun_sticky", DATA_W'(o_underrun), DATA_W'(1));

    // Write capture
    do_req(32'h100, 1'b1, 16'h000F, 128'h01234567_89ABCDEF_00112233_DEADBEEF, 4'd1);
    check("wr_pulse", DATA_W'(cap_wr), DATA_W'(1));
    check("wr_adr_lit", DATA_W'(cap_wadr), DATA_W'(32'h100));
    check("wr_sel_lit", DATA_W'(cap_wsel), DATA_W'(16'h000F));
    check("wr_dat_lit", cap_wdat, 128'h01234567_89ABCDEF_00112233_DEADBEEF);
    check("wr_single", DATA_W'(o_wr_valid), '0);
    check("wr_level", DATA_W'(o_level), '0);

    // Fill to full; a ninth push is refused
    i_ld_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      i_ld_word = 32'hA0 + i;
      @(negedge clk);
    end
    i_ld_valid = 1'b0;
    check("full_level", DATA_W'(o_level), DATA_W'(DEPTH));
    check("full_ready", DATA_W'(o_ld_ready), '0);
    do_req(32'h0, 1'b0, '1, '0, 4'd0);
    check("full_rd", cap_dat, 128'hF0081003_F0081003_F0081003_000000A0);
    check("full_rd_level", DATA_W'(cap_level), DATA_W'(DEPTH - 1));

    // Push and pop on the same edge
    i_ld_valid = 1'b1;
    i_ld_word  = 32'hB0;
    do_req(32'h4, 1'b0, '1, '0, 4'd0);
    check("pushpop_dat", cap_dat, 128'hF0081003_F0081003_000000A1_F0081003);
    check("pushpop_level", DATA_W'(cap_level), DATA_W'(DEPTH - 1));

    // Reset while waiting
    i_wb_adr = '0; i_wb_we = 1'b0; i_wait_cycles = 4'd5;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ack", DATA_W'(o_wb_ack), '0);
    check("midrst_level", DATA_W'(o_level), '0);
    check("midrst_ready", DATA_W'(o_ld_ready), DATA_W'(1));
    check("midrst_underrun", DATA_W'(o_underrun), '0);
    @(negedge clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    load(32'hCAFEF00D);
    do_req(32'h8, 1'b0, '1, '0, 4'd2);
    check("after_rst_dat", cap_dat, 128'hF0081003_CAFEF00D_F0081003_F0081003);
    check("after_rst_underrun", DATA_W'(cap_under), '0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
